sdr_input_conditioner: RTL and testbench
========================================

Name: sdr_input_conditioner

Overview:
Parametrised multi-channel front-end conditioner for the SDR receive path. It takes signed two's-complement ADC samples, optionally removes a calibrated DC offset, converts each sample to offset-binary, and applies a runtime-selectable power-of-two gain with half-up rounding and unsigned saturation. Results leave through a registered valid/ready stage. The block sits between the ADC capture logic and the first DSP stage (mixer/filter).

Parameters:
CH, 2, number of parallel channels (e.g. I/Q)
IN_W, 4, input sample width per channel, signed
OUT_W, 7, output sample width per channel, unsigned
SH_W, 3, width of gain_sh (gain shift range 0..2^SH_W-1)
CAL_LOG2, 4, log2 of calibration sample count N

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  CH*IN_W  channel k at bits [k*IN_W +: IN_W], signed
gain_sh  in  SH_W  gain shift; sampled on each input handshake
cal_start  in  1  single-cycle pulse; starts DC calibration
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out_data  out  CH*OUT_W  channel k at bits [k*OUT_W +: OUT_W], unsigned
cal_busy  out  1  high while state is CAL
sat_cnt  out  16  count of output samples with any channel clipped; saturates at 0xFFFF

Behaviour:
- Reset: reset is rst_n, asynchronous, active-low; clock is clk. On reset: out_valid=0, out_data=0, sat_cnt=0, cal_busy=0, every dc_est[k]=0, accumulators=0, state=IDLE.
- Handshake: in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready. Latency is 1 cycle: an accepted sample appears on out_data at the next edge with out_valid=1.
- Backpressure: while out_valid && !out_ready, out_data and out_valid hold stable. out_valid drops after an output handshake if no new input is accepted in that cycle.
- Per-channel arithmetic, for input x (signed IN_W):
  - d = x - dc_eff, computed at IN_W+1 bits signed. dc_eff = dc_est[k] in RUN, and 0 in IDLE and CAL.
  - u = d + 2^(IN_W-1), signed.
  - v = (u * 2^gain_sh + 1) >>> 1, arithmetic shift, at a width wide enough for the maximum shift.
  - out = 0 if v<0; 2^OUT_W-1 if v>2^OUT_W-1; otherwise v. Either clamp marks the channel as clipped.
- Saturation counting: sat_cnt increments by 1 at the input handshake whose result has at least one clipped channel. It holds at 0xFFFF.
- State machine:
  - IDLE: no DC subtraction. cal_start -> CAL.
  - CAL: accumulates x per channel into acc[k] (signed, IN_W+CAL_LOG2 bits) for each accepted sample. It counts N=2^CAL_LOG2 accepted samples. Samples still flow to the output with dc_eff=0. On acceptance of the N-th sample: dc_est[k] = (acc[k] + N/2) >>> CAL_LOG2, truncated to IN_W bits; acc cleared; next state RUN. cal_start is ignored while in CAL.
  - RUN: DC subtraction active. cal_start -> CAL, with acc and sample count cleared; dc_est is retained for the next result but not applied during CAL.
- Timing of cal_start: it is registered. A sample accepted in the cal_start cycle uses the prior state's dc_eff and is not accumulated. Accumulation begins with the first sample accepted after that cycle. The sample after the N-th uses the new dc_est.
- cal_busy = (state==CAL).
- Reset mid-calibration aborts: IDLE, dc_est=0.
- Input stalls during CAL only pause the count; there is no timeout.

Test Plan:
- Conversion, defaults, gain_sh=3, IDLE: in_data ch0=-8, ch1=7 -> out ch0=0, ch1=60; ch0=0 -> 32. out_valid rises 1 cycle after the handshake. sat_cnt stays 0.
- Rounding and gain: gain_sh=0, x=-7 -> 1; x=-8 -> 0; x=6 -> 7. gain_sh=1, x=0 -> 8.
- Saturation: gain_sh=5, x=7 -> 127 (v=240), sat_cnt=1. Then 3 more clipped samples -> sat_cnt=4. Force sat_cnt to 0xFFFF, send 1 more clipped sample -> stays 0xFFFF.
- Calibration, CAL_LOG2=2:
  - Pulse cal_start, then feed 4 samples ch0=3, ch1={-1,-2,-1,-2}. cal_busy is high during the 4 handshakes and clears after the 4th.
  - Result: dc_est ch0=3, ch1=(-6+2)>>>2=-1.
  - Next sample, gain_sh=3, ch0=3, ch1=-1 -> out 32, 32.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, no samples lost or duplicated across a 20-sample stream checked against the model.
- Reset mid-CAL: assert rst_n=0 after 2 of 4 calibration samples -> cal_busy=0, out_valid=0, dc_est=0. Subsequent x=3 at gain_sh=3 -> 44 (no subtraction).

Source files
------------

// File: rtl/sdr_input_conditioner.sv
// Multi-channel SDR front-end: optional DC removal, offset-binary conversion,
// power-of-two gain with half-up rounding and unsigned clamp, registered output.
module sdr_input_conditioner #(
  parameter int CH       = 2,
  parameter int IN_W     = 4,
  parameter int OUT_W    = 7,
  parameter int SH_W     = 3,
  parameter int CAL_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic [SH_W-1:0]       gain_sh,
  input  logic                  cal_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic                  cal_busy,
  output logic [15:0]           sat_cnt
);

  localparam int IW1 = IN_W + 1;
  localparam int UW  = IN_W + 2;
  localparam int VW  = UW + (1 << SH_W);
  localparam int AW  = IN_W + CAL_LOG2;
  localparam int AW1 = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic signed [UW-1:0]  BIAS     = UW'(2 ** (IN_W - 1));
  localparam logic signed [VW-1:0]  V_MAX    = VW'(2 ** OUT_W - 1);
  localparam logic signed [AW1-1:0] CAL_RND  = AW1'((2 ** CAL_LOG2) / 2);
  localparam logic [CAL_LOG2-1:0]   CNT_LAST = '1;

  logic [1:0]                state_q, state_d;
  logic [CAL_LOG2-1:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]      acc_q [CH];
  logic signed [AW-1:0]      acc_d [CH];
  logic signed [IN_W-1:0]    dc_est_q [CH];
  logic signed [IN_W-1:0]    dc_est_d [CH];
  logic                      out_valid_q, out_valid_d;
  logic [CH*OUT_W-1:0]       out_data_q, out_data_d;
  logic [15:0]               sat_cnt_q, sat_cnt_d;

  logic                      accept_s;
  logic signed [IN_W-1:0]    x_s      [CH];
  logic signed [IN_W-1:0]    dc_eff_s [CH];
  logic signed [IW1-1:0]     d_s      [CH];
  logic signed [UW-1:0]      u_s      [CH];
  logic signed [VW-1:0]      v_s      [CH];
  logic signed [AW1-1:0]     sum_s    [CH];
  logic signed [AW1-1:0]     rnd_s    [CH];
  logic signed [IN_W-1:0]    dc_new_s [CH];
  logic [CH*OUT_W-1:0]       res_s;
  logic [CH-1:0]             clip_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_cnt   = sat_cnt_q;
  assign cal_busy  = (state_q == ST_CAL);

  // Per-channel conversion and calibration running sum / rounded estimate.
  always_comb begin
    res_s  = '0;
    clip_s = '0;
    for (int k = 0; k < CH; k++) begin
      x_s[k] = $signed(in_data[k*IN_W +: IN_W]);
      if (state_q == ST_RUN) begin
        dc_eff_s[k] = dc_est_q[k];
      end else begin
        dc_eff_s[k] = '0;
      end
      d_s[k] = IW1'(x_s[k]) - IW1'(dc_eff_s[k]);
      u_s[k] = UW'(d_s[k]) + BIAS;
      // Half-up rounding of u*2^sh/2, kept wide enough for the largest shift.
      v_s[k] = ((VW'(u_s[k]) <<< gain_sh) + VW'(1)) >>> 1;
      if (v_s[k][VW-1]) begin
        res_s[k*OUT_W +: OUT_W] = '0;
        clip_s[k] = 1'b1;
      end else if (v_s[k] > V_MAX) begin
        res_s[k*OUT_W +: OUT_W] = '1;
        clip_s[k] = 1'b1;
      end else begin
        res_s[k*OUT_W +: OUT_W] = v_s[k][OUT_W-1:0];
        clip_s[k] = 1'b0;
      end
      sum_s[k]    = AW1'(acc_q[k]) + AW1'(x_s[k]);
      rnd_s[k]    = sum_s[k] + CAL_RND;
      dc_new_s[k] = IN_W'(rnd_s[k] >>> CAL_LOG2);
    end
  end

  // Mode FSM: cal_start takes effect from the next cycle, so the sample in
  // the request cycle is neither accumulated nor re-biased.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dc_est_d = dc_est_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (cal_start) begin
          state_d = ST_CAL;
          cnt_d   = '0;
          for (int k = 0; k < CH; k++) acc_d[k] = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_CAL: begin
        if (accept_s && (cnt_q == CNT_LAST)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          for (int k = 0; k < CH; k++) begin
            acc_d[k]    = '0;
            dc_est_d[k] = dc_new_s[k];
          end
        end else if (accept_s) begin
          cnt_d = cnt_q + CAL_LOG2'(1);
          for (int k = 0; k < CH; k++) acc_d[k] = AW'(sum_s[k]);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output stage and clip counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_cnt_d   = sat_cnt_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = res_s;
      if ((|clip_s) && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end else begin
        sat_cnt_d = sat_cnt_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_cnt_q   <= 16'd0;
      for (int k = 0; k < CH; k++) begin
        acc_q[k]    <= '0;
        dc_est_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_cnt_q   <= sat_cnt_d;
      for (int k = 0; k < CH; k++) begin
        acc_q[k]    <= acc_d[k];
        dc_est_q[k] <= dc_est_d[k];
      end
    end
  end

endmodule

// File: tb/tb_sdr_input_conditioner.sv
// Bench for sdr_input_conditioner: constant vector table, directed corner
// sequences and random traffic against an integer-arithmetic reference model.
module tb_sdr_input_conditioner;

  localparam int CH = 2, IN_W = 4, OUT_W = 7, SH_W = 3, CAL_LOG2 = 2;
  localparam int N = 1 << CAL_LOG2;
  localparam int OMAX = (1 << OUT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n, in_valid, in_ready, cal_start;
  logic                out_valid, out_ready, cal_busy;
  logic [CH*IN_W-1:0]  in_data;
  logic [SH_W-1:0]     gain_sh;
  logic [CH*OUT_W-1:0] out_data;
  logic [15:0]         sat_cnt;

  int checks = 0;
  int errors = 0;

  sdr_input_conditioner #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .CAL_LOG2(CAL_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .gain_sh(gain_sh), .cal_start(cal_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cal_busy(cal_busy), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 calibrating, 2 running.
  int m_mode, m_n, m_ov, m_sat, n_out, m_acc_cnt;
  int m_dc [CH];
  int m_sum[CH];
  int m_od [CH];
  int xin  [CH];
  logic [CH*OUT_W-1:0] sb[$];

  typedef struct { int x0; int x1; int sh; int e0; int e1; } vec_t;

  function automatic int fdiv(int a, int b);
    if (a >= 0) return a / b;
    else return -((-a + b - 1) / b);
  endfunction

  function automatic int conv(int x, int dc, int sh, output bit clip);
    int v;
    v = fdiv((x - dc + (1 << (IN_W - 1))) * (1 << sh) + 1, 2);
    clip = (v < 0) || (v > OMAX);
    if (v < 0) return 0;
    else if (v > OMAX) return OMAX;
    else return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_in(int x0, int x1, int sh, bit v);
    xin[0]   = x0;
    xin[1]   = x1;
    in_data  = {IN_W'(x1), IN_W'(x0)};
    gain_sh  = SH_W'(sh);
    in_valid = v;
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_ov = 0; m_sat = 0;
    for (int k = 0; k < CH; k++) begin
      m_dc[k] = 0; m_sum[k] = 0; m_od[k] = 0;
    end
    sb.delete();
  endtask

  // One clock: check in_ready / scoreboard before the edge, advance model.
  task automatic step();
    bit acc, clip, any;
    int rdy, dce;
    logic [CH*OUT_W-1:0] pk;
    pk = '0;
    #1;
    rdy = (m_ov == 0 || out_ready) ? 1 : 0;
    chk("in_ready", int'(in_ready), rdy);
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("sb_unexpected_output", 1, 0);
      else begin
        pk = sb.pop_front();
        chk("sb_data", int'(out_data), int'(pk));
      end
    end
    acc = in_valid && (rdy == 1);
    if (acc) begin
      any = 1'b0;
      for (int k = 0; k < CH; k++) begin
        dce = (m_mode == 2) ? m_dc[k] : 0;
        m_od[k] = conv(xin[k], dce, int'(gain_sh), clip);
        any = any | clip;
        pk[k*OUT_W +: OUT_W] = OUT_W'(m_od[k]);
      end
      sb.push_back(pk);
      m_ov = 1;
      m_acc_cnt++;
      if (any && m_sat < 65535) m_sat++;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (m_mode != 1 && cal_start) begin
      m_mode = 1; m_n = 0;
      for (int k = 0; k < CH; k++) m_sum[k] = 0;
    end else if (m_mode == 1 && acc) begin
      for (int k = 0; k < CH; k++) m_sum[k] += xin[k];
      m_n++;
      if (m_n == N) begin
        for (int k = 0; k < CH; k++) m_dc[k] = fdiv(m_sum[k] + N / 2, N);
        m_mode = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs();
    chk("out_valid", int'(out_valid), m_ov);
    chk("out_data_ch0", int'(out_data[0 +: OUT_W]), m_od[0]);
    chk("out_data_ch1", int'(out_data[OUT_W +: OUT_W]), m_od[1]);
    chk("sat_cnt", int'(sat_cnt), m_sat);
    chk("cal_busy", int'(cal_busy), (m_mode == 1) ? 1 : 0);
  endtask

  task automatic cyc();
    step();
    check_outs();
  endtask

  initial begin
    vec_t tbl[7];
    int c1[4];
    logic [CH*OUT_W-1:0] held;
    int n0;
    tbl[0] = '{-8,  7, 3,  0,  60};
    tbl[1] = '{ 0,  0, 3, 32,  32};
    tbl[2] = '{-7, -8, 0,  1,   0};
    tbl[3] = '{ 6,  6, 0,  7,   7};
    tbl[4] = '{ 0,  0, 1,  8,   8};
    tbl[5] = '{ 3, -1, 2, 22,  14};
    tbl[6] = '{-3,  5, 4, 40, 104};
    c1 = '{-1, -2, -1, -2};
    held = '0;
    n_out = 0;
    m_acc_cnt = 0;

    // Reset state.
    rst_n = 1'b0; cal_start = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 1'b0);
    model_reset();
    #2;
    check_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Conversion / rounding vectors in IDLE.
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].x0, tbl[i].x1, tbl[i].sh, 1'b1);
      cyc();
      chk("tbl_ch0", int'(out_data[0 +: OUT_W]), tbl[i].e0);
      chk("tbl_ch1", int'(out_data[OUT_W +: OUT_W]), tbl[i].e1);
    end
    chk("sat_idle_zero", int'(sat_cnt), 0);

    // Saturation counting and hold at 0xFFFF.
    set_in(7, 0, 5, 1'b1);
    cyc();
    chk("sat_first", int'(sat_cnt), 1);
    chk("sat_clip_out", int'(out_data[0 +: OUT_W]), 127);
    for (int i = 0; i < 3; i++) cyc();
    chk("sat_four", int'(sat_cnt), 4);
    set_in(7, 7, 5, 1'b1);
    force dut.sat_cnt_q = 16'hFFFF;
    m_sat = 65535;
    step();
    release dut.sat_cnt_q;
    check_outs();
    chk("sat_hold_max", int'(sat_cnt), 65535);
    set_in(0, 0, 0, 1'b1);
    cyc();

    // Calibration: 4 samples, ch0 = 3, ch1 = {-1,-2,-1,-2}.
    set_in(0, 0, 3, 1'b0);
    cal_start = 1'b1;
    cyc();
    cal_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(3, c1[i], 3, 1'b1);
      chk("cal_busy_hs", int'(cal_busy), 1);
      cyc();
    end
    chk("cal_done", int'(cal_busy), 0);
    set_in(3, -1, 3, 1'b1);
    cyc();
    chk("cal_out_ch0", int'(out_data[0 +: OUT_W]), 32);
    chk("cal_out_ch1", int'(out_data[OUT_W +: OUT_W]), 32);

    // Random traffic with occasional recalibration.
    for (int i = 0; i < 300; i++) begin
      set_in(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
             int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      cal_start = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    cal_start = 1'b0;

    // Backpressure: 20-sample stream with a 5-cycle stall.
    out_ready = 1'b1;
    set_in(0, 0, 0, 1'b0);
    cyc();
    n0 = n_out;
    m_acc_cnt = 0;
    for (int c = 0; c < 200 && m_acc_cnt < 20; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (c == 3) held = out_data;
      if (c == 8) chk("bp_data_stable", int'(out_data), int'(held));
      set_in(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
             int'($urandom_range(0, 7)), 1'b1);
      cyc();
    end
    set_in(0, 0, 0, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk("bp_outputs", n_out - n0, 20);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset in the middle of calibration.
    set_in(0, 0, 3, 1'b0);
    cal_start = 1'b1;
    cyc();
    cal_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(3, -1, 3, 1'b1);
      cyc();
    end
    rst_n = 1'b0;
    set_in(0, 0, 3, 1'b0);
    model_reset();
    #2;
    chk("rst_cal_busy", int'(cal_busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dc_est0", int'(dut.dc_est_q[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(3, 3, 3, 1'b1);
    cyc();
    chk("post_rst_ch0", int'(out_data[0 +: OUT_W]), 44);
    chk("post_rst_ch1", int'(out_data[OUT_W +: OUT_W]), 44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
